// File: rtl/arbitro_breg.sv
// rtl/arbitro_breg.sv - round-robin write-port arbiter and RAW/WAW scoreboard for the register file
// Optional write-to-read forwarding is enabled by defining BREG_BYPASS_EN.
module arbitro_breg #(
  parameter int ANCHO = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_val,
  input  logic [4:0]       req0_dir,
  input  logic [ANCHO-1:0] req0_dato,
  output logic             req0_listo,
  input  logic             req1_val,
  input  logic [4:0]       req1_dir,
  input  logic [ANCHO-1:0] req1_dato,
  output logic             req1_listo,
  input  logic             reserva,
  input  logic [4:0]       dirreserva,
  input  logic [4:0]       dirlec1,
  input  logic [4:0]       dirlec2,
  output logic [ANCHO-1:0] datolec1,
  output logic [ANCHO-1:0] datolec2,
  output logic             espera,
  output logic [4:0]       diresc,
  output logic [ANCHO-1:0] datoesc,
  output logic             enesc,
  output logic [4:0]       dirlec1_b,
  output logic [4:0]       dirlec2_b,
  input  logic [ANCHO-1:0] datolec1_b,
  input  logic [ANCHO-1:0] datolec2_b,
  output logic [31:0]      ocupado
);

  logic             r_ultimo;
  logic             r_enesc;
  logic [4:0]       r_diresc;
  logic [ANCHO-1:0] r_datoesc;
  logic [31:0]      r_ocupado;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_xfer;
  logic [4:0]       w_dir_sel;
  logic [ANCHO-1:0] w_dato_sel;
  logic [31:0]      w_ocupado_nxt;
  logic             w_byp1;
  logic             w_byp2;

  // r_ultimo = 1 means req1 was granted last, so req0 wins the next tie.
  assign w_gnt0     = !rst && req0_val && (!req1_val || r_ultimo);
  assign w_gnt1     = !rst && req1_val && (!req0_val || !r_ultimo);
  assign w_xfer     = w_gnt0 || w_gnt1;
  assign w_dir_sel  = w_gnt0 ? req0_dir  : req1_dir;
  assign w_dato_sel = w_gnt0 ? req0_dato : req1_dato;

  assign req0_listo = w_gnt0;
  assign req1_listo = w_gnt1;

  always_comb begin
    w_ocupado_nxt = r_ocupado;
    if (r_enesc) begin
      w_ocupado_nxt[r_diresc] = 1'b0;
    end
    // Applied after the clear so a fresh reservation of the same register survives.
    if (reserva && (dirreserva != 5'd0)) begin
      w_ocupado_nxt[dirreserva] = 1'b1;
    end
    w_ocupado_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ultimo  <= 1'b1;
      r_enesc   <= 1'b0;
      r_diresc  <= 5'd0;
      r_datoesc <= '0;
      r_ocupado <= 32'd0;
    end else begin
      if (w_xfer) begin
        r_ultimo  <= w_gnt1;
        r_diresc  <= w_dir_sel;
        r_datoesc <= w_dato_sel;
        r_enesc   <= (w_dir_sel != 5'd0);
      end else begin
        r_enesc   <= 1'b0;
      end
      r_ocupado <= w_ocupado_nxt;
    end
  end

`ifdef BREG_BYPASS_EN
  assign w_byp1 = r_enesc && (dirlec1 == r_diresc) && (r_diresc != 5'd0);
  assign w_byp2 = r_enesc && (dirlec2 == r_diresc) && (r_diresc != 5'd0);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  // The WAW term uses the raw busy bit: forwarding only helps readers.
  assign espera = (r_ocupado[dirlec1] && !w_byp1) ||
                  (r_ocupado[dirlec2] && !w_byp2) ||
                  (reserva && r_ocupado[dirreserva]);

  assign datolec1  = w_byp1 ? r_datoesc : datolec1_b;
  assign datolec2  = w_byp2 ? r_datoesc : datolec2_b;
  assign dirlec1_b = dirlec1;
  assign dirlec2_b = dirlec2;

  assign enesc   = r_enesc;
  assign diresc  = r_diresc;
  assign datoesc = r_datoesc;
  assign ocupado = r_ocupado;

endmodule
